// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory access arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_AW = 5;
  localparam int unsigned DEF_DW = 32;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Port indices
  localparam logic P_FETCH = 1'b0;
  localparam logic P_LSU   = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick; combinational, evaluated only while the top is idle.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_c_o,
  output logic grant_idx_c_o
);

  // Single requester wins outright; on a tie the port not granted last time wins
  always_comb begin
    valid_c_o     = req0_i | req1_i;
    grant_idx_c_o = P_FETCH;
    if (req0_i && req1_i) begin
      grant_idx_c_o = ~last_grant_i;
    end else if (req1_i) begin
      grant_idx_c_o = P_LSU;
    end
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares one data-memory port between the fetch/loader port (0) and the LSU port (1).
// One access in flight; out-of-range addresses complete with an error and no strobe.
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned ACC_CYCLES = 1,
  parameter int unsigned MEM_DEPTH  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic          p0_err,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic          p1_err,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d_in,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_d_out,
  output logic          busy
);

  localparam int unsigned CW  = $clog2(ACC_CYCLES + 1);
  localparam int unsigned AW1 = AW + 1;
  localparam logic [AW:0] DEPTH_LIM = AW1'(MEM_DEPTH);

  arb_state_e    state_q;
  logic          last_grant_q;
  logic          gnt_q;
  logic          we_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic          arb_valid;
  logic          arb_idx;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_err;

  rr_arbiter2 u_rr (
    .req0_i        (p0_req),
    .req1_i        (p1_req),
    .last_grant_i  (last_grant_q),
    .valid_c_o     (arb_valid),
    .grant_idx_c_o (arb_idx)
  );

  // Steer the winning port's request fields and classify its address
  always_comb begin
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (arb_idx == P_LSU) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
    sel_err = ({1'b0, sel_addr} >= DEPTH_LIM);
  end

  // Access FSM with registered memory strobes, responses and read-data holding registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= P_LSU;
      gnt_q        <= P_FETCH;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      p0_ack       <= 1'b0;
      p0_err       <= 1'b0;
      p0_rdata     <= '0;
      p1_ack       <= 1'b0;
      p1_err       <= 1'b0;
      p1_rdata     <= '0;
      mem_addr     <= '0;
      mem_d_in     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p0_err <= 1'b0;
      p1_ack <= 1'b0;
      p1_err <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt_q        <= arb_idx;
            last_grant_q <= arb_idx;
            we_q         <= sel_we;
            err_q        <= sel_err;
            cnt_q        <= CW'(ACC_CYCLES - 1);
            mem_addr     <= sel_addr;
            mem_d_in     <= sel_wdata;
            mem_rd       <= ~sel_we & ~sel_err;
            mem_wr       <= sel_we & ~sel_err;
            busy         <= 1'b1;
            state_q      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            if (!we_q && !err_q) begin
              if (gnt_q == P_LSU) p1_rdata <= mem_d_out;
              else                p0_rdata <= mem_d_out;
            end
            if (gnt_q == P_LSU) begin
              p1_ack <= 1'b1;
              p1_err <= err_q;
            end else begin
              p0_ack <= 1'b1;
              p0_err <= err_q;
            end
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_RESP: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Scoreboard bench: two arbiter instances (1-cycle and 4-cycle access) each behind a memory model.
module tb_dmem_access_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst4_n, mem_load;

  logic          p0_req, p0_we, p0_ack, p0_err, p1_req, p1_we, p1_ack, p1_err;
  logic [AW-1:0] p0_addr, p1_addr, mem_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_d_in, mem_d_out;
  logic          mem_rd, mem_wr, busy;

  logic          q0_req, q0_we, q0_ack, q0_err, q1_req, q1_we, q1_ack, q1_err;
  logic [AW-1:0] q0_addr, q1_addr, m4_addr;
  logic [DW-1:0] q0_wdata, q1_wdata, q0_rdata, q1_rdata, m4_d_in, m4_d_out;
  logic          m4_rd, m4_wr, busy4;

  dmem_access_arbiter #(.AW(AW), .DW(DW), .ACC_CYCLES(1), .MEM_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_d_out(mem_d_out), .busy(busy)
  );

  dmem_access_arbiter #(.AW(AW), .DW(DW), .ACC_CYCLES(4), .MEM_DEPTH(16)) dut4 (
    .clk(clk), .rst_n(rst4_n),
    .p0_req(q0_req), .p0_we(q0_we), .p0_addr(q0_addr), .p0_wdata(q0_wdata),
    .p0_ack(q0_ack), .p0_err(q0_err), .p0_rdata(q0_rdata),
    .p1_req(q1_req), .p1_we(q1_we), .p1_addr(q1_addr), .p1_wdata(q1_wdata),
    .p1_ack(q1_ack), .p1_err(q1_err), .p1_rdata(q1_rdata),
    .mem_addr(m4_addr), .mem_d_in(m4_d_in), .mem_rd(m4_rd), .mem_wr(m4_wr),
    .mem_d_out(m4_d_out), .busy(busy4)
  );

  // Memory models: combinational read, write on rising edge
  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 3) ? 32'h42F3_0000 : (32'hA000_0000 | 32'(i));
  endfunction

  logic [DW-1:0] mem  [0:31];
  logic [DW-1:0] mem4 [0:31];
  assign mem_d_out = mem[mem_addr];
  assign m4_d_out  = mem4[m4_addr];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) begin
        mem[i]  <= init_val(i);
        mem4[i] <= init_val(i);
      end
    end else begin
      if (mem_wr) mem[mem_addr] <= mem_d_in;
      if (m4_wr)  mem4[m4_addr] <= m4_d_in;
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    logic          port;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  req_t reqq0[$];
  req_t reqq1[$];
  exp_t exp_q[$];
  int   ack_cyc[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  bit chk_busy = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Present the head of each port's pending list, or drop req when empty
  task automatic drive_ports();
    if (reqq0.size() > 0) begin
      p0_req = 1'b1; p0_we = reqq0[0].we; p0_addr = reqq0[0].addr; p0_wdata = reqq0[0].wdata;
    end else begin
      p0_req = 1'b0;
    end
    if (reqq1.size() > 0) begin
      p1_req = 1'b1; p1_we = reqq1[0].we; p1_addr = reqq1[0].addr; p1_wdata = reqq1[0].wdata;
    end else begin
      p1_req = 1'b0;
    end
  endtask

  task automatic push_req(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wd;
    if (port) reqq1.push_back(r);
    else      reqq0.push_back(r);
    drive_ports();
  endtask

  task automatic push_exp(input logic port, input logic err, input logic [DW-1:0] rdata);
    exp_t e;
    e.port = port; e.err = err; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Advance one clock, sample after the edge, score any ack, then update requesters
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    check_val("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
    if (mem_rd || mem_wr) strobe_cnt++;
    if (chk_busy) check_val("busy", 32'(busy), 32'(mem_rd | mem_wr | p0_ack | p1_ack));
    if (p0_ack || p1_ack) begin
      ack_cyc.push_back(cyc);
      check_val("dual_ack", 32'(p0_ack & p1_ack), 32'd0);
      check_val("exp_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("ack_port", 32'(p1_ack), 32'(e.port));
        if (e.port) begin
          check_val("p1_err", 32'(p1_err), 32'(e.err));
          check_val("p1_rdata", p1_rdata, e.rdata);
        end else begin
          check_val("p0_err", 32'(p0_err), 32'(e.err));
          check_val("p0_rdata", p0_rdata, e.rdata);
        end
      end
    end
    if (p0_ack && reqq0.size() > 0) void'(reqq0.pop_front());
    if (p1_ack && reqq1.size() > 0) void'(reqq1.pop_front());
    drive_ports();
  endtask

  task automatic wait_acks(input int n, input int budget);
    int tgt;
    int k;
    tgt = ack_cyc.size() + n;
    k = 0;
    while (ack_cyc.size() < tgt && k < budget) begin
      step();
      k++;
    end
    check_val("ack_timeout", 32'(ack_cyc.size()), 32'(tgt));
  endtask

  int c0;
  int base;
  int k;
  int ack4_seen;

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0; mem_load = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    q0_req = 0; q0_we = 0; q0_addr = '0; q0_wdata = '0;
    q1_req = 0; q1_we = 0; q1_addr = '0; q1_wdata = '0;
    repeat (3) step();
    mem_load = 1'b0;

    // Reset state
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_acks", 32'({p0_ack, p1_ack, p0_err, p1_err}), 32'd0);
    check_val("rst_p0_rdata", p0_rdata, 32'd0);
    check_val("rst_p1_rdata", p1_rdata, 32'd0);
    check_val("rst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_d_in", mem_d_in, 32'd0);
    rst_n = 1'b1; rst4_n = 1'b1;
    chk_busy = 1'b1;

    // p0 read of preloaded word, latency 2
    c0 = cyc;
    push_exp(1'b0, 1'b0, 32'h42F3_0000);
    push_req(1'b0, 1'b0, 5'd3, '0);
    wait_acks(1, 10);
    check_val("t1_latency", 32'(ack_cyc[ack_cyc.size()-1]), 32'(c0 + 2));
    step();
    check_val("t1_ack_pulse", 32'(p0_ack), 32'd0);

    // p1 write then p0 reads it back
    push_exp(1'b1, 1'b0, 32'd0);
    push_req(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    wait_acks(1, 10);
    step();
    push_exp(1'b0, 1'b0, 32'hDEAD_BEEF);
    push_req(1'b0, 1'b0, 5'd5, '0);
    wait_acks(1, 10);
    step();
    check_val("t2_p1_rdata", p1_rdata, 32'd0);

    // Out-of-range read: error ack, no strobes, rdata untouched
    chk_busy = 1'b0;
    strobe_cnt = 0;
    push_exp(1'b1, 1'b1, 32'd0);
    push_req(1'b1, 1'b0, 5'd20, '0);
    wait_acks(1, 10);
    step();
    check_val("t3_no_strobe", 32'(strobe_cnt), 32'd0);
    chk_busy = 1'b1;

    // Both ports held from reset: alternating grants, 3 cycles apart
    rst_n = 1'b0;
    step();
    step();
    check_val("t4_rst_rdata", p0_rdata, 32'd0);
    push_exp(1'b0, 1'b0, 32'h42F3_0000);
    push_exp(1'b1, 1'b0, 32'hDEAD_BEEF);
    push_exp(1'b0, 1'b0, 32'h42F3_0000);
    push_exp(1'b1, 1'b0, 32'h1111_2222);
    push_req(1'b0, 1'b0, 5'd3, '0);
    push_req(1'b0, 1'b1, 5'd7, 32'h1111_2222);
    push_req(1'b1, 1'b0, 5'd5, '0);
    push_req(1'b1, 1'b0, 5'd7, '0);
    rst_n = 1'b1;
    base = ack_cyc.size();
    wait_acks(4, 30);
    for (int i = 1; i < 4; i++) begin
      if (base + i < ack_cyc.size())
        check_val("t4_spacing", 32'(ack_cyc[base+i] - ack_cyc[base+i-1]), 32'd3);
    end
    step();

    // p0 streams three reads, p1 joins during the first
    push_exp(1'b0, 1'b0, 32'hA000_0000);
    push_exp(1'b1, 1'b0, 32'hA000_0004);
    push_exp(1'b0, 1'b0, 32'hA000_0001);
    push_exp(1'b0, 1'b0, 32'hA000_0002);
    push_req(1'b0, 1'b0, 5'd0, '0);
    push_req(1'b0, 1'b0, 5'd1, '0);
    push_req(1'b0, 1'b0, 5'd2, '0);
    step();
    push_req(1'b1, 1'b0, 5'd4, '0);
    wait_acks(4, 40);
    step();
    check_val("t6_exp_drained", 32'(exp_q.size()), 32'd0);

    // 4-cycle access instance: latency, then reset during the 2nd access cycle
    q0_req = 1'b1; q0_we = 1'b0; q0_addr = 5'd3;
    c0 = cyc;
    k = 0;
    while (!q0_ack && k < 20) begin
      step();
      k++;
    end
    check_val("t5_latency", 32'(cyc), 32'(c0 + 5));
    check_val("t5_rdata", q0_rdata, 32'h42F3_0000);
    q0_req = 1'b0;
    step();
    check_val("t5_ack_pulse", 32'(q0_ack), 32'd0);
    q0_req = 1'b1; q0_addr = 5'd5;
    step();
    check_val("t5_busy_access", 32'(busy4), 32'd1);
    check_val("t5_rd_access", 32'(m4_rd), 32'd1);
    step();
    rst4_n = 1'b0;
    q0_req = 1'b0;
    step();
    check_val("t5_rst_ack", 32'({q0_ack, q0_err, q1_ack, q1_err}), 32'd0);
    check_val("t5_rst_rdata", q0_rdata, 32'd0);
    check_val("t5_rst_busy", 32'(busy4), 32'd0);
    check_val("t5_rst_strobes", 32'({m4_rd, m4_wr}), 32'd0);
    check_val("t5_rst_addr", 32'(m4_addr), 32'd0);
    rst4_n = 1'b1;
    ack4_seen = 0;
    repeat (6) begin
      step();
      if (q0_ack) ack4_seen++;
    end
    check_val("t5_no_ack", 32'(ack4_seen), 32'd0);
    check_val("t5_idle_busy", 32'(busy4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
